// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB; define TLB_FILL_LFSR_EN for an LFSR-based TLBFILL replacement index
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  localparam int IDXW = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      op_code,
  input  logic [4:0]      op_inv_op,
  input  logic [9:0]      op_inv_asid,
  input  logic [18:0]     op_inv_vppn,
  input  logic [IDXW-1:0] csr_index,
  input  logic [5:0]      csr_ps,
  input  logic            csr_ne,
  input  logic [18:0]     csr_vppn,
  input  logic [9:0]      csr_asid,
  input  logic            csr_g,
  input  logic [25:0]     csr_elo0,
  input  logic [25:0]     csr_elo1,
  output logic [18:0]     s1_vppn,
  output logic [9:0]      s1_asid,
  input  logic            s1_found,
  input  logic [IDXW-1:0] s1_index,
  output logic            we,
  output logic [IDXW-1:0] w_index,
  output logic [88:0]     w_entry,
  output logic [IDXW-1:0] r_index,
  input  logic [88:0]     r_entry,
  output logic            invtlb_valid,
  output logic [4:0]      invtlb_op,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [2:0]      resp_code,
  output logic            resp_ne,
  output logic [IDXW-1:0] resp_index,
  output logic [88:0]     resp_entry,
  output logic            resp_ine
);
  localparam logic [2:0] OP_SRCH = 3'd0, OP_RD = 3'd1, OP_WR = 3'd2, OP_FILL = 3'd3, OP_INV = 3'd4;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic accept;
  logic [IDXW-1:0] rep_idx;
  logic [2:0] code_q;
  logic [4:0] inv_op_q;
  logic [9:0] inv_asid_q, asid_q;
  logic [18:0] inv_vppn_q, vppn_q;
  logic [IDXW-1:0] index_q, fill_q;
  logic [5:0] ps_q;
  logic e_q, g_q;
  logic [25:0] elo0_q, elo1_q;
  logic inv_ok;
  assign accept = op_valid && op_ready;
  assign inv_ok = inv_op_q <= 5'd6;
`ifdef TLB_FILL_LFSR_EN
  logic [15:0] lfsr;
  // Fibonacci LFSR, taps 16/14/13/11, steps every cycle
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) lfsr <= 16'hACE1;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign rep_idx = lfsr[IDXW-1:0];
`else
  logic [IDXW-1:0] rep_cnt;
  // free-running wrap counter used as the fill victim index
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) rep_cnt <= '0;
    else rep_cnt <= (rep_cnt == IDXW'(TLBNUM - 1)) ? '0 : rep_cnt + 1'b1;
  assign rep_idx = rep_cnt;
`endif
  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  // next-state logic: IDLE -> EXEC -> RESP -> IDLE
  always_comb begin
    state_n = (state == IDLE && op_valid) ? EXEC :
              (state == EXEC) ? RESP :
              (state == RESP && resp_ready) ? IDLE : state;
  end
  // handshake and one-cycle TLB strobes decoded from state
  always_comb begin
    op_ready = state == IDLE;
    resp_valid = state == RESP;
    we = state == EXEC && (code_q == OP_WR || code_q == OP_FILL);
    invtlb_valid = state == EXEC && code_q == OP_INV && inv_ok;
  end
  // capture the whole request at accept so the CSRs may move during the op
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      code_q <= '0;
      inv_op_q <= '0;
      inv_asid_q <= '0;
      inv_vppn_q <= '0;
      index_q <= '0;
      fill_q <= '0;
      ps_q <= '0;
      e_q <= 1'b0;
      vppn_q <= '0;
      asid_q <= '0;
      g_q <= 1'b0;
      elo0_q <= '0;
      elo1_q <= '0;
    end else if (accept) begin
      code_q <= op_code;
      inv_op_q <= op_inv_op;
      inv_asid_q <= op_inv_asid;
      inv_vppn_q <= op_inv_vppn;
      index_q <= csr_index;
      fill_q <= rep_idx;
      ps_q <= csr_ps;
      e_q <= ~csr_ne;
      vppn_q <= csr_vppn;
      asid_q <= csr_asid;
      g_q <= csr_g;
      elo0_q <= csr_elo0;
      elo1_q <= csr_elo1;
    end
  // register TLB search/read results at the end of EXEC; held through RESP
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      resp_ne <= 1'b0;
      resp_index <= '0;
      resp_entry <= '0;
      resp_ine <= 1'b0;
    end else if (state == EXEC) begin
      resp_ne <= (code_q == OP_SRCH) ? ~s1_found : (code_q == OP_RD) ? ~r_entry[88] : 1'b0;
      resp_index <= (code_q == OP_SRCH) ? s1_index : '0;
      resp_entry <= (code_q == OP_RD && r_entry[88]) ? r_entry : '0;
      resp_ine <= code_q > OP_INV || (code_q == OP_INV && !inv_ok);
    end
  assign resp_code = code_q;
  assign s1_vppn = (code_q == OP_INV) ? inv_vppn_q : vppn_q;
  assign s1_asid = (code_q == OP_INV) ? inv_asid_q : asid_q;
  assign r_index = index_q;
  assign w_index = (code_q == OP_FILL) ? fill_q : index_q;
  assign w_entry = {e_q, vppn_q, ps_q, asid_q, g_q, elo1_q, elo0_q};
  assign invtlb_op = inv_op_q;
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: directed + random ops against a TLB array model and a reference result model
module tb_tlb_op_ctrl;
  localparam int N = 16;
  localparam int W = 4;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic op_valid = 1'b0, op_ready;
  logic [2:0] op_code = '0;
  logic [4:0] op_inv_op = '0;
  logic [9:0] op_inv_asid = '0;
  logic [18:0] op_inv_vppn = '0;
  logic [W-1:0] csr_index = '0;
  logic [5:0] csr_ps = '0;
  logic csr_ne = 1'b0;
  logic [18:0] csr_vppn = '0;
  logic [9:0] csr_asid = '0;
  logic csr_g = 1'b0;
  logic [25:0] csr_elo0 = '0, csr_elo1 = '0;
  logic [18:0] s1_vppn;
  logic [9:0] s1_asid;
  logic s1_found;
  logic [W-1:0] s1_index;
  logic we;
  logic [W-1:0] w_index;
  logic [88:0] w_entry;
  logic [W-1:0] r_index;
  logic [88:0] r_entry;
  logic invtlb_valid;
  logic [4:0] invtlb_op;
  logic resp_valid, resp_ready = 1'b0;
  logic [2:0] resp_code;
  logic resp_ne;
  logic [W-1:0] resp_index;
  logic [88:0] resp_entry;
  logic resp_ine;

  tlb_op_ctrl #(.TLBNUM(N)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_inv_op(op_inv_op), .op_inv_asid(op_inv_asid), .op_inv_vppn(op_inv_vppn),
    .csr_index(csr_index), .csr_ps(csr_ps), .csr_ne(csr_ne), .csr_vppn(csr_vppn),
    .csr_asid(csr_asid), .csr_g(csr_g), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1),
    .s1_vppn(s1_vppn), .s1_asid(s1_asid), .s1_found(s1_found), .s1_index(s1_index),
    .we(we), .w_index(w_index), .w_entry(w_entry), .r_index(r_index), .r_entry(r_entry),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_code(resp_code), .resp_ne(resp_ne), .resp_index(resp_index),
    .resp_entry(resp_entry), .resp_ine(resp_ine)
  );

  always #5 clk = ~clk;

  // TLB array as seen by the DUT: written through the DUT's write port
  logic [88:0] tlb [N] = '{default: '0};
  always @(posedge clk) if (we) tlb[w_index] <= w_entry;
  always_comb begin
    s1_found = 1'b0;
    s1_index = '0;
    for (int i = N - 1; i >= 0; i--)
      if (tlb[i][88] && tlb[i][87:69] == s1_vppn && (tlb[i][52] || tlb[i][62:53] == s1_asid)) begin
        s1_found = 1'b1;
        s1_index = W'(i);
      end
  end
  assign r_entry = tlb[r_index];

  // reference: cycles since reset give the expected fill index
  int cyc;
  logic [15:0] m_lfsr;
  logic [W-1:0] rep_model;
  always @(posedge clk or negedge resetn)
    if (!resetn) begin
      cyc <= 0;
      m_lfsr <= 16'hACE1;
    end else begin
      cyc <= cyc + 1;
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
`ifdef TLB_FILL_LFSR_EN
  assign rep_model = m_lfsr[W-1:0];
`else
  assign rep_model = W'(cyc % N);
`endif

  logic [88:0] ref_tlb [N] = '{default: '0};
  int n_total = 0, n_pass = 0;
  logic [2:0] x_code;
  logic x_ne, x_ine;
  logic [W-1:0] x_index;
  logic [88:0] x_entry;
  logic x_chk_index;
  logic [W-1:0] last_w;

  task automatic chk(input string tag, input logic [88:0] obs, input logic [88:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_resp();
    chk("resp_valid", resp_valid, 1);
    chk("resp_code", resp_code, x_code);
    chk("resp_ne", resp_ne, x_ne);
    chk("resp_ine", resp_ine, x_ine);
    chk("resp_entry", resp_entry, x_entry);
    if (x_chk_index) chk("resp_index", resp_index, x_index);
  endtask

  task automatic run_op(input logic [2:0] code, input logic [4:0] iop, input logic [9:0] iasid,
                        input logic [18:0] ivppn, input logic [W-1:0] idx, input logic [18:0] vppn,
                        input logic [9:0] asid, input logic ne, input logic g, input int hold);
    logic [88:0] ent;
    logic [W-1:0] fidx, widx;
    int k;
    @(negedge clk);
    op_valid = 1'b1; op_code = code; op_inv_op = iop; op_inv_asid = iasid; op_inv_vppn = ivppn;
    csr_index = idx; csr_vppn = vppn; csr_asid = asid; csr_ne = ne; csr_g = g;
    csr_ps = 6'($urandom); csr_elo0 = 26'($urandom); csr_elo1 = 26'($urandom);
    resp_ready = (hold == 0);
    k = 0;
    while (!op_ready && k < 10) begin @(negedge clk); k++; end
    chk("accept_ready", op_ready, 1);
    fidx = rep_model;
    ent = {~ne, vppn, csr_ps, asid, g, csr_elo1, csr_elo0};
    x_code = code;
    x_ine = code > 3'd4 || (code == 3'd4 && iop > 5'd6);
    x_ne = 1'b0; x_index = '0; x_entry = '0; x_chk_index = 1'b0;
    if (code == 3'd0) begin
      x_ne = 1'b1;
      for (int i = 0; i < N; i++)
        if (x_ne && ref_tlb[i][88] && ref_tlb[i][87:69] == vppn && (ref_tlb[i][52] || ref_tlb[i][62:53] == asid)) begin
          x_ne = 1'b0; x_index = W'(i); x_chk_index = 1'b1;
        end
    end
    if (code == 3'd1) begin
      x_ne = !ref_tlb[idx][88];
      x_entry = ref_tlb[idx][88] ? ref_tlb[idx] : '0;
    end
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'($urandom); op_inv_op = 5'($urandom); op_inv_asid = 10'($urandom);
    op_inv_vppn = 19'($urandom); csr_index = W'($urandom); csr_vppn = 19'($urandom);
    csr_asid = 10'($urandom); csr_ne = 1'($urandom); csr_g = 1'($urandom);
    csr_ps = 6'($urandom); csr_elo0 = 26'($urandom); csr_elo1 = 26'($urandom);
    chk("op_ready_exec", op_ready, 0);
    chk("resp_valid_exec", resp_valid, 0);
    chk("we_exec", we, code == 3'd2 || code == 3'd3);
    if (code == 3'd2 || code == 3'd3) begin
      widx = (code == 3'd2) ? idx : fidx;
      chk("w_index", w_index, widx);
      chk("w_entry", w_entry, ent);
      last_w = w_index;
      ref_tlb[widx] = ent;
    end
    chk("inv_valid_exec", invtlb_valid, code == 3'd4 && iop <= 5'd6);
    if (code == 3'd4 && iop <= 5'd6) begin
      chk("invtlb_op", invtlb_op, iop);
      chk("inv_s1_asid", s1_asid, iasid);
      chk("inv_s1_vppn", s1_vppn, ivppn);
    end
    if (code == 3'd0) begin
      chk("s1_vppn", s1_vppn, vppn);
      chk("s1_asid", s1_asid, asid);
    end
    if (code == 3'd1) chk("r_index", r_index, idx);
    @(posedge clk); #1;
    chk("we_resp", we, 0);
    chk("inv_valid_resp", invtlb_valid, 0);
    chk("op_ready_resp", op_ready, 0);
    chk_resp();
    if (hold > 0) begin
      op_valid = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        chk("op_ready_hold", op_ready, 0);
        chk_resp();
      end
      op_valid = 1'b0;
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("resp_valid_done", resp_valid, 0);
    chk("op_ready_done", op_ready, 1);
  endtask

  initial begin
    logic [W-1:0] f0;
    #1;
    chk("rst_op_ready", op_ready, 1);
    chk("rst_we", we, 0);
    chk("rst_inv", invtlb_valid, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_w_entry", w_entry, 0);
    chk("rst_resp_entry", resp_entry, 0);
    chk("rst_resp_ine", resp_ine, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    run_op(3'd2, 0, 0, 0, 4'd3, 19'h1234, 10'h5, 1'b0, 1'b0, 0);
    chk("wr3_e", tlb[3][88], 1);
    run_op(3'd0, 0, 0, 0, 0, 19'h1234, 10'h5, 0, 0, 0);
    chk("srch_hit_ne", resp_ne, 0);
    chk("srch_hit_idx", resp_index, 3);
    run_op(3'd0, 0, 0, 0, 0, 19'h1235, 10'h5, 0, 0, 0);
    chk("srch_miss_ne", resp_ne, 1);
    run_op(3'd1, 0, 0, 0, 4'd5, 0, 0, 0, 0, 0);
    chk("rd5_ne", resp_ne, 1);
    run_op(3'd1, 0, 0, 0, 4'd3, 0, 0, 0, 0, 0);
    chk("rd3_entry", resp_entry, tlb[3]);
    run_op(3'd4, 5'd5, 10'h7, 19'h1234, 0, 0, 0, 0, 0, 0);
    run_op(3'd4, 5'd9, 10'h7, 19'h1234, 0, 0, 0, 0, 0, 0);
    chk("inv9_ine", resp_ine, 1);
    run_op(3'd6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_op(3'd2, 0, 0, 0, 4'd9, 19'h2222, 10'h6, 1'b0, 1'b1, 4);
    // reset pulse during EXEC of a TLBWR to index 7
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd2; csr_index = 4'd7; csr_ne = 1'b0; csr_vppn = 19'h3333;
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("mid_we_before", we, 1);
    resetn = 1'b0;
    #1;
    chk("mid_we_reset", we, 0);
    chk("mid_op_ready", op_ready, 1);
    chk("mid_resp_valid", resp_valid, 0);
    @(negedge clk);
    resetn = 1'b1;
    run_op(3'd1, 0, 0, 0, 4'd7, 0, 0, 0, 0, 0);
    run_op(3'd3, 0, 0, 0, 0, 19'h4444, 10'h1, 1'b0, 1'b0, 0);
    f0 = last_w;
    run_op(3'd3, 0, 0, 0, 0, 19'h4445, 10'h1, 1'b0, 1'b0, 0);
`ifndef TLB_FILL_LFSR_EN
    chk("fill_delta", W'(last_w - f0), 3);
`endif
    for (int t = 0; t < 40; t++)
      run_op(3'($urandom_range(0, 7)), 5'($urandom_range(0, 10)), 10'($urandom_range(5, 6)),
             19'($urandom_range(19'h1234, 19'h1237)), W'($urandom), 19'($urandom_range(19'h1234, 19'h1237)),
             10'($urandom_range(5, 6)), 1'($urandom_range(0, 3) == 0), 1'($urandom), $urandom_range(0, 2));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
